// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared constants for the 7-segment display path.
//   Segment vectors are ordered {a,b,c,d,e,f,g} = [6:0], with 1 meaning lit.
//   Contents:
//     SEG_DASH     segment pattern for the dash code (g only)
//     SEG_BLANK    all segments off
//     CODE_DASH    nibble code that renders as a dash
//     DIGIT_TABLE  segment patterns for the decimal digits 0..9
package seg_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] CODE_DASH = 4'hF;

  // Entry [n] is the pattern for digit n. The concatenation lists entry 9 first
  // because it becomes the most significant element of the packed array.
  localparam logic [9:0][6:0] DIGIT_TABLE = {
    7'b1111011,  // 9 abcdfg
    7'b1111111,  // 8 abcdefg
    7'b1110000,  // 7 abc
    7'b1011111,  // 6 acdefg
    7'b1011011,  // 5 acdfg
    7'b0110011,  // 4 bcfg
    7'b1111001,  // 3 abcdg
    7'b1101101,  // 2 abdeg
    7'b0110000,  // 1 bc
    7'b1111110   // 0 abcdef
  };

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder
//   Combinational nibble to 7-segment decoder.
//   Codes 0-9 give the standard digits, 10-14 give a blank, and 15 gives a dash.
//   Ports:
//     code  in   4  nibble to display
//     seg   out  7  {a,b,c,d,e,f,g}, 1 = lit (active-high; polarity is handled by the caller)
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Codes 10-14 are deliberately left blank. That lets the upstream stage
  // suppress a digit, for example a leading zero, while keeping its decimal point.
  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9) begin
      seg = DIGIT_TABLE[code];
    end else if (code == CODE_DASH) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexes a packed 4-digit code word onto one 4-digit 7-segment bank.
//   The word and the decimal points are captured once per frame, at the wrap from
//   digit 3 to digit 0, so a frame never mixes old and new digits. Each digit slot
//   starts with BLANK_CYC cycles in which every digit select is off, which
//   suppresses ghosting while the select lines change.
//   Parameters:
//     SCAN_DIV     clk cycles per digit slot (>= 4)
//     BLANK_CYC    dark cycles at the start of each slot (0..SCAN_DIV-1)
//     SEG_ACT_LOW  1 = segment lines are active-low
//     CS_ACT_LOW   1 = digit selects are active-low
//   Ports:
//     clk          in   1   system clock
//     rst          in   1   asynchronous, active-high reset
//     data         in   16  digit codes, digit i = data[4i+3:4i], digit 3 leftmost
//     dp           in   4   decimal point per digit, bit i -> digit i
//     seg_data     out  8   {a,b,c,d,e,f,g,dp}
//     seg_cs       out  4   one-hot digit select, bit i -> digit i
//     frame_start  out  1   1-cycle pulse in the cycle after data/dp are captured
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned BLANK_CYC   = 1_000,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          CS_ACT_LOW  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  output logic [7:0]  seg_data,
  output logic [3:0]  seg_cs,
  output logic        frame_start
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK_CYC);

  localparam logic [7:0] SEG_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0] CS_IDLE  = CS_ACT_LOW  ? 4'hF  : 4'h0;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow_data;
  logic [3:0]       shadow_dp;
  logic             live;
  logic             tick;
  logic             in_blank;
  logic [3:0]       cur_code;
  logic [6:0]       cur_seg7;
  logic [7:0]       seg_raw;
  logic [3:0]       cs_raw;

  assign tick = (div_cnt == DIV_LAST);

  // With BLANK_CYC = 0 there is no dark window. Handling that case separately
  // avoids an unsigned compare against zero, which would always be false.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (div_cnt < BLANK_V);
    end
  endgenerate

  // Slot timing. The index resets to 3 so that the first tick wraps it to 0,
  // which is also the moment the first word is captured.
  // 'live' keeps the outputs dark until a real word has been captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= 2'd3;
      shadow_data <= '0;
      shadow_dp   <= '0;
      live        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
        if (idx == 2'd3) begin
          shadow_data <= data;
          shadow_dp   <= dp;
          live        <= 1'b1;
          frame_start <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign cur_code = shadow_data[{idx, 2'b00} +: 4];

  seg_decoder u_decoder (
    .code (cur_code),
    .seg  (cur_seg7)
  );

  assign seg_raw = {cur_seg7, shadow_dp[idx]};
  assign cs_raw  = 4'b0001 << idx;

  // Output register. It lags div_cnt/idx by one cycle, so when a slot changes the
  // old digit stays lit for one more cycle and then goes dark for BLANK_CYC cycles
  // before the new digit appears. No two selects are ever active together.
  // Polarity is applied last, so the timing is identical for either polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data <= SEG_IDLE;
      seg_cs   <= CS_IDLE;
    end else if (live && !in_blank) begin
      seg_data <= SEG_ACT_LOW ? ~seg_raw : seg_raw;
      seg_cs   <= CS_ACT_LOW  ? ~cs_raw  : cs_raw;
    end else begin
      seg_data <= SEG_IDLE;
      seg_cs   <= CS_IDLE;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Directed bench for seg_scan_driver with SCAN_DIV=8 and BLANK_CYC=2.
//   Two instances share the stimulus: one with active-high polarity and one with
//   active-low polarity. Expected segment bytes are hand-decoded per scenario.
//   Expected timing, with edge t counted from reset release and u = t-1:
//     - Outputs sampled after edge t reflect slot position u.
//     - A digit is lit when u >= 8 and u%8 >= 2.
//     - The lit digit is (u/8-1)%4, and the frame number is (u/8-1)/4.
//     - frame_start is high after edge t exactly when t%32 == 8.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;

  logic [7:0]  seg_p, seg_n;
  logic [3:0]  cs_p, cs_n;
  logic        fs_p, fs_n;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACT_LOW(1'b0), .CS_ACT_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rst(rst), .data(data), .dp(dp),
    .seg_data(seg_p), .seg_cs(cs_p), .frame_start(fs_p)
  );

  seg_scan_driver #(
    .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACT_LOW(1'b1), .CS_ACT_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .rst(rst), .data(data), .dp(dp),
    .seg_data(seg_n), .seg_cs(cs_n), .frame_start(fs_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " cs_hi"},  {28'd0, cs_p},  32'h0);
    checkOutput({tag, " seg_hi"}, {24'd0, seg_p}, 32'h00);
    checkOutput({tag, " fs_hi"},  {31'd0, fs_p},  32'h0);
    checkOutput({tag, " cs_lo"},  {28'd0, cs_n},  32'hF);
    checkOutput({tag, " seg_lo"}, {24'd0, seg_n}, 32'hFF);
    checkOutput({tag, " fs_lo"},  {31'd0, fs_n},  32'h0);
  endtask

  // Holds reset for 5 cycles with the new inputs applied, checks the idle
  // outputs, then releases reset on a falling edge.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    rst  = 1'b1;
    data = d;
    dp   = p;
    repeat (5) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
  endtask

  task automatic runScan(input int n_edges, input int change_at,
                         input logic [15:0] new_data, input int abort_at);
    int u, slot, dig, fr;
    logic [3:0] e_cs;
    logic [7:0] e_seg;
    logic       e_fs;
    for (int t = 1; t <= n_edges; t++) begin
      @(negedge clk);
      u     = t - 1;
      e_cs  = 4'h0;
      e_seg = 8'h00;
      e_fs  = ((t % 32) == 8);
      if (u >= 8 && (u % 8) >= 2) begin
        slot  = u / 8 - 1;
        dig   = slot % 4;
        fr    = slot / 4;
        e_cs  = 4'b0001 << dig;
        e_seg = (fr == 0) ? exp_a[dig] : exp_b[dig];
      end
      checkOutput($sformatf("cs_hi t=%0d", t),  {28'd0, cs_p},  {28'd0, e_cs});
      checkOutput($sformatf("seg_hi t=%0d", t), {24'd0, seg_p}, {24'd0, e_seg});
      checkOutput($sformatf("fs_hi t=%0d", t),  {31'd0, fs_p},  {31'd0, e_fs});
      checkOutput($sformatf("cs_lo t=%0d", t),  {28'd0, cs_n},  {28'd0, ~e_cs});
      checkOutput($sformatf("seg_lo t=%0d", t), {24'd0, seg_n}, {24'd0, ~e_seg});
      checkOutput($sformatf("fs_lo t=%0d", t),  {31'd0, fs_n},  {31'd0, e_fs});
      checkOutput($sformatf("onehot0 t=%0d", t), {31'd0, $onehot0(cs_p)}, 32'd1);
      if (t == change_at) data = new_data;
      if (t == abort_at) begin
        #2 rst = 1'b1;
        #1 checkIdle($sformatf("async rst t=%0d", t));
        return;
      end
    end
  endtask

  initial begin
    $display("[TB] seg_scan_driver bench start");

    // 1F23 with dp on digit 2: shows 3, 2, dash+dp, 1 from digit 0 upward.
    exp_a = '{8'hF2, 8'hDA, 8'h03, 8'h60};
    exp_b = exp_a;
    applyStimulus(16'h1F23, 4'b0100);
    runScan(48, 0, 16'h0, 0);

    // Word changes while digit 1 is lit. The rest of the frame keeps 1234,
    // and 5678 appears from the next frame.
    exp_a = '{8'h66, 8'hF2, 8'hDA, 8'h60};
    exp_b = '{8'hFE, 8'hE0, 8'hBE, 8'hB6};
    applyStimulus(16'h1234, 4'b0000);
    runScan(72, 18, 16'h5678, 0);

    // All eights: the active-low instance must show 8'h01.
    exp_a = '{8'hFE, 8'hFE, 8'hFE, 8'hFE};
    exp_b = exp_a;
    applyStimulus(16'h8888, 4'b0000);
    runScan(40, 0, 16'h0, 0);

    // Blank codes keep their decimal points. Reset is pulsed while digit 2 is lit.
    exp_a = '{8'hF6, 8'h01, 8'hFC, 8'h01};
    exp_b = exp_a;
    applyStimulus(16'hA0E9, 4'b1010);
    runScan(28, 0, 16'h0, 28);

    // After the mid-frame reset the scan restarts at digit 0 with the same timing.
    applyStimulus(16'hA0E9, 4'b1010);
    runScan(40, 0, 16'h0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
